sb_config_loader: RTL and testbench
===================================

SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

Interface
REQ-001 Parameters SHALL be, one per line:
- CONFIG_WIDTH, 264, total configuration bits of one switch box.
- WORD_WIDTH, 8, width of one load word.
REQ-002 Ports SHALL be, one per line:
- clock  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new load session.
- data_in  input  WORD_WIDTH  incoming configuration or check word.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  loader accepts data_in this cycle.
- commit  input  1  one-cycle pulse that transfers the shadow register to the active register.
- config_out  output  CONFIG_WIDTH  active configuration, driving the switch box config_in.
- config_valid  output  1  config_out holds a committed image.
- loaded  output  1  the shadow register holds a complete, checked image.
- busy  output  1  a load session is in progress.
- error  output  1  sticky flag; cleared only by start or reset.
REQ-003 A word SHALL transfer only in a cycle where data_valid and data_ready are both 1.

Function
REQ-004 NUM_WORDS SHALL equal CONFIG_WIDTH/WORD_WIDTH, which is 33. CONFIG_WIDTH not divisible by WORD_WIDTH SHALL be an elaboration error.
REQ-005 The states SHALL be IDLE, LOAD, CHECK and FULL.
REQ-006 IDLE: data_ready=0 and busy=0. On start, go to LOAD, clear the word counter, clear the shadow register, clear the running XOR and clear error.
REQ-007 LOAD: data_ready=1 and busy=1. Data word k (k = 0..32) SHALL be written to shadow[k*8+7:k*8], LSB-first order. Each word is XORed into the running checksum and the counter increments.
REQ-008 When word 32 transfers, the state SHALL become CHECK in the next cycle. The counter SHALL NOT wrap.
REQ-009 CHECK: data_ready=1 and busy=1. The single transferred word SHALL be compared with the running XOR of the 33 data words.
- Equal: go to FULL.
- Unequal: set error, leave loaded at 0, go to IDLE.
REQ-010 FULL: data_ready=0, busy=0 and loaded=1. Further words SHALL be stalled (not accepted) and SHALL NOT raise error.
REQ-011 Commit in FULL SHALL load config_out from the shadow register on that clock edge and set config_valid=1. The state then becomes IDLE and loaded becomes 0 in the next cycle.
REQ-012 Commit in IDLE SHALL be ignored; outputs are unchanged.
REQ-013 Commit in LOAD or CHECK SHALL abort the session: set error, go to IDLE, leave config_out and config_valid unchanged.
REQ-014 Start in any state (LOAD, CHECK, FULL) SHALL restart per REQ-006. A pending shadow image is discarded and config_out is unchanged.
REQ-015 If start and commit occur in the same cycle, start SHALL win and commit SHALL be ignored.
REQ-016 If start and data_valid occur in the same cycle in LOAD, start SHALL win and the word SHALL be dropped.
REQ-017 config_out SHALL change only on a successful commit and SHALL hold stable at all other times, including during a reload.
REQ-018 All outputs SHALL be registered or decoded from the state register only. There SHALL be no combinational path from any input to any output.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL enter IDLE and clear all of the following to 0: counter, running XOR, shadow, config_out, config_valid, loaded, busy, error, data_ready.
REQ-020 Reset asserted in the middle of a session SHALL discard the session completely. After reset, only a new start begins a load.

Structure
REQ-021 Package kfpga_config_pkg SHALL hold CONFIG_WIDTH, WORD_WIDTH, NUM_WORDS, the counter width (clog2 of NUM_WORDS+1) and the state enum type.
REQ-022 The block SHALL be a single module with no sub-modules. One instance sits beside each SwitchBox, with config_out connected directly to that box's config_in.

Verification
REQ-023 Nominal load:
- Stimulus: start, then words 0x00..0x20 with no gaps, then check word 0x20, then commit.
- Response: loaded=1 one cycle after the check word transfers; after commit, config_out[7:0]=0x00 and config_out[263:256]=0x20; config_valid=1.
REQ-024 Bad checksum:
- Stimulus: same 33 words, then check word 0x21.
- Response: error=1, loaded=0, state IDLE; config_out unchanged at its previous value (0 after reset).
REQ-025 Backpressure and gaps:
- Stimulus: data_valid toggled randomly during the load, plus 5 extra words offered in FULL.
- Response: exactly 34 words accepted; data_ready=0 in FULL; error stays 0.
REQ-026 Early commit and restart:
- Stimulus: commit after 10 words.
- Response: error=1 and config_out unchanged.
- Stimulus: then start.
- Response: error=0, busy=1, counter restarted at word 0.
REQ-027 Reset in the middle of a load:
- Stimulus: reset asserted after 20 words.
- Response: every output is 0 on the next cycle, and commit without a new start does nothing.
REQ-028 Same-cycle start and commit in FULL:
- Response: the state goes to LOAD, config_out is not updated, and loaded=0.

Source files
------------

// File: rtl/kfpga_config_pkg.sv
// ============================================================================
// Module      : kfpga_config_pkg
// Description : Shared sizing constants and loader state type for the
//               switch-box configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kfpga_config_pkg;

    localparam int CONFIG_WIDTH = 264;
    localparam int WORD_WIDTH   = 8;
    localparam int NUM_WORDS    = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_WIDTH    = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        FULL  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sb_config_loader.sv
// ============================================================================
// Module      : sb_config_loader
// Description : Word-serial loader that assembles a switch-box image in a
//               shadow register, validates it with an XOR check word and
//               transfers it to the active configuration on commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = kfpga_config_pkg::CONFIG_WIDTH,
    parameter int WORD_WIDTH   = kfpga_config_pkg::WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    commit,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    loaded,
    output logic                    busy,
    output logic                    error
);

    localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_WIDTH = $clog2(NUM_WORDS + 1);

    generate
        if ((CONFIG_WIDTH % WORD_WIDTH) != 0) begin : g_width_check
            $error("CONFIG_WIDTH must be a multiple of WORD_WIDTH");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   xor_q, xor_d;
    logic                    error_q, error_d;
    logic                    cfg_valid_q, cfg_valid_d;
    logic [CONFIG_WIDTH-1:0] config_q;
    logic [WORD_WIDTH-1:0]   shadow_q [NUM_WORDS];
    logic [CONFIG_WIDTH-1:0] w_shadow_flat;
    logic                    w_shadow_clr;
    logic                    w_word_we;
    logic                    w_cfg_load;

    // Start has priority over everything else, including commit and data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        xor_d        = xor_q;
        error_d      = error_q;
        cfg_valid_d  = cfg_valid_q;
        w_shadow_clr = 1'b0;
        w_word_we    = 1'b0;
        w_cfg_load   = 1'b0;

        if (start) begin
            state_d      = LOAD;
            cnt_d        = '0;
            xor_d        = '0;
            error_d      = 1'b0;
            w_shadow_clr = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (commit) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (data_valid) begin
                        w_word_we = 1'b1;
                        xor_d     = xor_q ^ data_in;
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == CNT_WIDTH'(NUM_WORDS - 1)) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (commit) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else if (data_valid) begin
                        if (data_in == xor_q) begin
                            state_d = FULL;
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                FULL: begin
                    if (commit) begin
                        w_cfg_load  = 1'b1;
                        cfg_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xor_q       <= '0;
            error_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            error_q     <= error_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    // Word k of the session lands in bits [k*WORD_WIDTH +: WORD_WIDTH].
    always_ff @(posedge clock) begin
        if (reset || w_shadow_clr) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (w_word_we) begin
            shadow_q[cnt_q] <= data_in;
        end
    end

    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_flat
            assign w_shadow_flat[k*WORD_WIDTH +: WORD_WIDTH] = shadow_q[k];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            config_q <= '0;
        end else if (w_cfg_load) begin
            config_q <= w_shadow_flat;
        end
    end

    assign data_ready   = (state_q == LOAD) || (state_q == CHECK);
    assign busy         = (state_q == LOAD) || (state_q == CHECK);
    assign loaded       = (state_q == FULL);
    assign error        = error_q;
    assign config_valid = cfg_valid_q;
    assign config_out   = config_q;

endmodule

`default_nettype wire

// File: tb/tb_sb_config_loader.sv
// ============================================================================
// Module      : tb_sb_config_loader
// Description : Self-checking bench for sb_config_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sb_config_loader;

    localparam int CW = 264;
    localparam int WW = 8;
    localparam int NW = CW / WW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          commit = 1'b0;
    logic [CW-1:0] config_out;
    logic          config_valid;
    logic          loaded;
    logic          busy;
    logic          error;

    sb_config_loader #(
        .CONFIG_WIDTH (CW),
        .WORD_WIDTH   (WW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .commit       (commit),
        .config_out   (config_out),
        .config_valid (config_valid),
        .loaded       (loaded),
        .busy         (busy),
        .error        (error)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            acc_words = 0;
    bit            mon_en = 1'b0;
    logic [CW-1:0] prev_cfg = '0;
    logic [CW-1:0] last_img = '0;
    logic [CW-1:0] exp_q [$];

    typedef struct {
        int        pat;
        logic [7:0] off;
        logic      exp_loaded;
        logic      exp_error;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_word(input int p, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        case (p)
            0:       return kb * 8'd3 + 8'd1;
            1:       return 8'hA5 ^ kb;
            2:       return ~kb;
            3:       return kb * kb + 8'd7;
            4:       return kb ^ 8'h3C;
            5:       return kb + 8'h40;
            6:       return 8'hF0 - kb;
            default: return kb;
        endcase
    endfunction

    // Scoreboard: every config_out change must match the oldest expectation.
    always @(negedge clock) begin
        if (mon_en && (config_out !== prev_cfg)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL cfg_unexpected_change: got %0h expected %0h", config_out, prev_cfg);
            end else begin
                chk("cfg_scoreboard", config_out, exp_q.pop_front());
            end
            prev_cfg = config_out;
        end
    end

    task automatic offer(input logic [7:0] w);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        data_in = w;
        data_valid = 1'b1;
        while (!done && t < 50) begin
            done = data_ready;
            if (done) acc_words++;
            @(negedge clock);
            t++;
        end
        data_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL offer_timeout: got no transfer expected transfer of %0h", w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clock);
        commit = 1'b0;
    endtask

    task automatic load_words(input int p, input bit gaps, output logic [CW-1:0] img, output logic [7:0] xr);
        logic [7:0] w;
        img = '0;
        xr = '0;
        for (int k = 0; k < NW; k++) begin
            w = gen_word(p, k);
            if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
            offer(w);
            img[k*WW +: WW] = w;
            xr ^= w;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] img;
        logic [7:0]    xr;

        vecs[0] = '{0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{2, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{3, 8'h00, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_config_out", config_out, '0);
        chk("rst_config_valid", config_valid, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_data_ready", data_ready, 0);
        reset = 1'b0;
        prev_cfg = '0;
        mon_en = 1'b1;
        @(negedge clock);

        // Bad checksum after reset
        pulse_start();
        chk("start_busy", busy, 1);
        load_words(7, 1'b0, img, xr);
        offer(8'h21);
        chk("bad_error", error, 1);
        chk("bad_loaded", loaded, 0);
        chk("bad_busy", busy, 0);
        chk("bad_ready", data_ready, 0);
        chk("bad_cfg_unchanged", config_out, '0);
        chk("bad_cfg_valid", config_valid, 0);

        // Nominal load 0x00..0x20, check word 0x20
        pulse_start();
        chk("restart_clears_error", error, 0);
        load_words(7, 1'b0, img, xr);
        offer(8'h20);
        chk("nom_loaded", loaded, 1);
        chk("nom_busy", busy, 0);
        chk("nom_cfg_held", config_out, '0);
        exp_q.push_back(img);
        last_img = img;
        pulse_commit();
        chk("nom_byte0", config_out[7:0], 8'h00);
        chk("nom_byte32", config_out[263:256], 8'h20);
        chk("nom_cfg_valid", config_valid, 1);
        chk("nom_loaded_after_commit", loaded, 0);
        pulse_commit();
        chk("idle_commit_ignored", config_out, last_img);

        // Table of sessions
        foreach (vecs[i]) begin
            pulse_start();
            load_words(vecs[i].pat, 1'b0, img, xr);
            offer(xr ^ vecs[i].off);
            chk("tbl_loaded", loaded, vecs[i].exp_loaded);
            chk("tbl_error", error, vecs[i].exp_error);
            chk("tbl_busy", busy, 0);
            if (vecs[i].exp_loaded) begin
                exp_q.push_back(img);
                last_img = img;
                pulse_commit();
                chk("tbl_cfg_valid", config_valid, 1);
            end else begin
                chk("tbl_cfg_unchanged", config_out, last_img);
            end
        end

        // Backpressure with gaps plus extra words offered in FULL
        acc_words = 0;
        pulse_start();
        load_words(4, 1'b1, img, xr);
        offer(xr);
        chk("bp_loaded", loaded, 1);
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(i);
            data_valid = 1'b1;
            if (data_ready) acc_words++;
            @(negedge clock);
        end
        data_valid = 1'b0;
        chk("bp_accepted", acc_words, 34);
        chk("bp_error", error, 0);
        chk("bp_ready_full", data_ready, 0);
        chk("bp_still_loaded", loaded, 1);
        exp_q.push_back(img);
        last_img = img;
        pulse_commit();

        // Early commit aborts, start restarts at word 0
        pulse_start();
        for (int k = 0; k < 10; k++) offer(gen_word(4, k));
        pulse_commit();
        chk("early_error", error, 1);
        chk("early_busy", busy, 0);
        chk("early_cfg_unchanged", config_out, last_img);
        pulse_start();
        chk("early_restart_error", error, 0);
        chk("early_restart_busy", busy, 1);
        start = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        data_valid = 1'b0;
        chk("start_data_busy", busy, 1);
        load_words(5, 1'b0, img, xr);
        offer(xr);
        chk("restart_loaded", loaded, 1);
        exp_q.push_back(img);
        last_img = img;
        pulse_commit();

        // Same-cycle start and commit in FULL
        pulse_start();
        load_words(6, 1'b0, img, xr);
        offer(xr);
        chk("sc_loaded_before", loaded, 1);
        start = 1'b1;
        commit = 1'b1;
        @(negedge clock);
        start = 1'b0;
        commit = 1'b0;
        chk("sc_busy", busy, 1);
        chk("sc_loaded", loaded, 0);
        chk("sc_ready", data_ready, 1);
        chk("sc_cfg_unchanged", config_out, last_img);

        // Reset in the middle of a load
        pulse_start();
        for (int k = 0; k < 20; k++) offer(gen_word(0, k));
        exp_q.push_back('0);
        last_img = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mr_config_out", config_out, '0);
        chk("mr_config_valid", config_valid, 0);
        chk("mr_loaded", loaded, 0);
        chk("mr_busy", busy, 0);
        chk("mr_error", error, 0);
        chk("mr_ready", data_ready, 0);
        pulse_commit();
        @(negedge clock);
        chk("mr_commit_cfg", config_out, '0);
        chk("mr_commit_valid", config_valid, 0);
        chk("mr_commit_busy", busy, 0);

        @(negedge clock);
        chk("sb_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
